// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Shared definitions for the multi-approach traffic-light
//               controller: FSM state encoding, default timing constants and
//               a helper that sizes the phase index.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2,
    ST_NIGHT  = 2'd3
  } state_t;

  localparam int DEF_N_PHASES    = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_T_GREEN_MIN = 10;
  localparam int DEF_T_GREEN_MAX = 30;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 2;

  // Width of an approach index; never narrower than one bit.
  function automatic int phase_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : semaforo_pkg
`default_nettype wire

// File: rtl/semaforo_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_multi_if
// Description : Detector / lamp bundle of the traffic-light controller.
//   car   : per-approach vehicle detector (to controller)
//   night : flashing-yellow mode request  (to controller)
//   grn, ylw, red : lamp drives per approach (from controller)
//   phase : current or last-served approach index (from controller)
//   Modports: master = environment side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface semaforo_multi_if
  import semaforo_pkg::*;
#(
  parameter int N_PHASES = DEF_N_PHASES
);
  localparam int PH_W = phase_width(N_PHASES);

  logic [N_PHASES-1:0] car;
  logic                night;
  logic [N_PHASES-1:0] grn;
  logic [N_PHASES-1:0] ylw;
  logic [N_PHASES-1:0] red;
  logic [PH_W-1:0]     phase;

  modport master (output car, night, input grn, ylw, red, phase);
  modport slave  (input car, night, output grn, ylw, red, phase);

endinterface : semaforo_multi_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches req starting at
//               last+1 and wrapping; last itself is examined last.
//   req   : request vector
//   last  : index of the most recently served requester
//   grant : index of the selected requester (0 when valid=0)
//   valid : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import semaforo_pkg::*;
#(
  parameter int N = DEF_N_PHASES
) (
  input  logic [N-1:0]                 req,
  input  logic [phase_width(N)-1:0]    last,
  output logic [phase_width(N)-1:0]    grant,
  output logic                         valid
);
  localparam int PH_W = phase_width(N);

  always_comb begin : p_search
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    // Walk from farthest to nearest so the nearest hit is written last.
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant = PH_W'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/semaforo_multi.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_multi
// Description : Demand-driven traffic-light controller for N_PHASES
//               approaches with minimum/maximum green, yellow and all-red
//               intervals, plus a flashing-yellow night mode.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides every input)
//   bus  : semaforo_multi_if.slave (car, night in; grn, ylw, red, phase out)
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_multi
  import semaforo_pkg::*;
#(
  parameter int N_PHASES    = DEF_N_PHASES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED
) (
  input  logic              clk,
  input  logic              rst,
  semaforo_multi_if.slave   bus
);
  localparam int PH_W = phase_width(N_PHASES);

  // Timer thresholds: a state lasting T cycles leaves when timer reaches T-1.
  localparam logic [CNT_W-1:0] C_GMIN_M1 = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX_M1 = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL_M1  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_AR_M1   = CNT_W'(T_ALLRED - 1);
  localparam logic [N_PHASES-1:0] C_ONE  = N_PHASES'(1);

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_timer, w_timer_n;
  logic [CNT_W-1:0]    r_blink, w_blink_n;
  logic [PH_W-1:0]     r_phase, w_phase_n;
  logic [N_PHASES-1:0] r_pending, w_pending_n;
  logic [N_PHASES-1:0] r_grn, r_ylw, r_red;
  logic [N_PHASES-1:0] w_grn_n, w_ylw_n, w_red_n;

  logic [N_PHASES-1:0] w_onehot_cur, w_onehot_n, w_set, w_clr;
  logic                w_other_pending, w_car_here, w_entry;
  logic [PH_W-1:0]     w_grant;
  logic                w_grant_valid;

  rr_arbiter #(.N(N_PHASES)) u_arb (
    .req   (r_pending),
    .last  (r_phase),
    .grant (w_grant),
    .valid (w_grant_valid)
  );

  assign w_onehot_cur    = C_ONE << r_phase;
  assign w_other_pending = |(r_pending & ~w_onehot_cur);
  assign w_car_here      = |(bus.car & w_onehot_cur);

  // Next state and phase selection.
  always_comb begin : p_fsm
    w_state_n = r_state;
    w_phase_n = r_phase;
    unique case (r_state)
      ST_GREEN: begin
        // Demand from elsewhere ends green early only once the local
        // approach is empty; otherwise the maximum green caps it.
        if ((r_timer >= C_GMIN_M1) &&
            (bus.night || (w_other_pending && (!w_car_here || (r_timer >= C_GMAX_M1)))))
          w_state_n = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (r_timer >= C_YEL_M1) w_state_n = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (r_timer >= C_AR_M1) begin
          if (bus.night) begin
            w_state_n = ST_NIGHT;
          end else begin
            w_state_n = ST_GREEN;
            if (w_grant_valid) w_phase_n = w_grant;
          end
        end
      end
      ST_NIGHT: begin
        if (!bus.night) w_state_n = ST_ALLRED;
      end
      default: w_state_n = ST_GREEN;
    endcase
  end

  // Timer, pending requests and registered lamp values derived from the
  // next state so lamps switch on the same edge as the state.
  always_comb begin : p_datapath
    w_entry     = (w_state_n != r_state);
    w_timer_n   = w_entry ? '0 : ((r_timer == '1) ? r_timer : r_timer + 1'b1);
    w_onehot_n  = C_ONE << w_phase_n;
    w_set       = bus.car & ((r_state == ST_GREEN) ? ~w_onehot_cur : '1);
    // Entry into green for an approach clears its request, beating a set.
    w_clr       = (w_entry && (w_state_n == ST_GREEN)) ? w_onehot_n : '0;
    w_pending_n = (r_pending | w_set) & ~w_clr;

    w_blink_n = '0;
    w_grn_n   = '0;
    w_ylw_n   = '0;
    w_red_n   = '0;
    unique case (w_state_n)
      ST_GREEN: begin
        w_grn_n = w_onehot_n;
        w_red_n = ~w_onehot_n;
      end
      ST_YELLOW: begin
        w_ylw_n = w_onehot_n;
        w_red_n = ~w_onehot_n;
      end
      ST_ALLRED: begin
        w_red_n = '1;
      end
      ST_NIGHT: begin
        // Blink counter runs independently of the saturating state timer.
        if (w_entry) begin
          w_ylw_n = '1;
        end else if (r_blink >= C_YEL_M1) begin
          w_ylw_n = ~r_ylw;
        end else begin
          w_ylw_n   = r_ylw;
          w_blink_n = r_blink + 1'b1;
        end
      end
      default: begin
        w_red_n = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      r_state   <= ST_GREEN;
      r_timer   <= '0;
      r_blink   <= '0;
      r_phase   <= '0;
      r_pending <= '0;
      r_grn     <= C_ONE;
      r_ylw     <= '0;
      r_red     <= ~C_ONE;
    end else begin
      r_state   <= w_state_n;
      r_timer   <= w_timer_n;
      r_blink   <= w_blink_n;
      r_phase   <= w_phase_n;
      r_pending <= w_pending_n;
      r_grn     <= w_grn_n;
      r_ylw     <= w_ylw_n;
      r_red     <= w_red_n;
    end
  end

  assign bus.grn   = r_grn;
  assign bus.ylw   = r_ylw;
  assign bus.red   = r_red;
  assign bus.phase = r_phase;

endmodule : semaforo_multi
`default_nettype wire

// File: tb/tb_semaforo_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_multi
// Description : Self-checking bench for semaforo_multi (3 approaches,
//               green 4..8, yellow 2, all-red 1). A table of per-cycle
//               {inputs, expected lamps/phase} rows is applied in a loop,
//               followed by hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_multi;

  localparam int N = 3;

  localparam int K_G  = 0;  // green on approach p
  localparam int K_Y  = 1;  // yellow on approach p
  localparam int K_A  = 2;  // all red
  localparam int K_N1 = 3;  // night, yellows lit
  localparam int K_N0 = 4;  // night, everything dark

  typedef struct {
    logic       rst;
    logic       night;
    logic [2:0] car;
    logic [2:0] grn;
    logic [2:0] ylw;
    logic [2:0] red;
    logic [1:0] phase;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  semaforo_multi_if #(.N_PHASES(N)) bus ();

  semaforo_multi #(
    .N_PHASES    (N),
    .CNT_W       (8),
    .T_GREEN_MIN (4),
    .T_GREEN_MAX (8),
    .T_YELLOW    (2),
    .T_ALLRED    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Append rep identical rows; lamp expectations follow from the kind code.
  task automatic add(input logic r, input logic n, input logic [2:0] c,
                     input int kind, input int p, input int rep = 1);
    vec_t       v;
    logic [2:0] oh;
    oh = 3'b001 << p;
    v.rst   = r;
    v.night = n;
    v.car   = c;
    v.phase = 2'(p);
    v.grn   = 3'b000;
    v.ylw   = 3'b000;
    v.red   = 3'b000;
    case (kind)
      K_G:  begin v.grn = oh; v.red = ~oh; end
      K_Y:  begin v.ylw = oh; v.red = ~oh; end
      K_A:  v.red = 3'b111;
      K_N1: v.ylw = 3'b111;
      default: ;
    endcase
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic step(input logic r, input logic n, input logic [2:0] c);
    @(negedge clk);
    rst       = r;
    bus.night = n;
    bus.car   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [2:0] eg, input logic [2:0] ey,
                       input logic [2:0] er, input logic [1:0] ep);
    checks++;
    if (bus.grn !== eg || bus.ylw !== ey || bus.red !== er || bus.phase !== ep) begin
      errors++;
      $display("FAIL %s #%0d: got grn=%b ylw=%b red=%b phase=%0d, want grn=%b ylw=%b red=%b phase=%0d",
               name, idx, bus.grn, bus.ylw, bus.red, bus.phase, eg, ey, er, ep);
    end
  endtask

  initial begin : p_main
    int cyc;
    rst       = 1'b1;
    bus.night = 1'b0;
    bus.car   = 3'b000;

    // Reset then idle: phase 0 green throughout.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 0, 3'b000, K_G, 0, 20);
    // Single request on approach 2.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 0, 3'b100, K_G, 0);
    add(0, 0, 3'b000, K_G, 0, 2);
    add(0, 0, 3'b000, K_Y, 0, 2);
    add(0, 0, 3'b000, K_A, 0);
    add(0, 0, 3'b000, K_G, 2, 4);
    // Approach 0 busy while approach 1 waits: green stretched to max.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 0, 3'b011, K_G, 0);
    add(0, 0, 3'b001, K_G, 0, 6);
    add(0, 0, 3'b001, K_Y, 0, 2);
    add(0, 0, 3'b001, K_A, 0);
    add(0, 0, 3'b000, K_G, 1, 4);
    add(0, 0, 3'b000, K_Y, 1, 2);
    add(0, 0, 3'b000, K_A, 1);
    add(0, 0, 3'b000, K_G, 0, 3);
    // Two pending approaches served in round-robin order.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 0, 3'b110, K_G, 0);
    add(0, 0, 3'b000, K_G, 0, 2);
    add(0, 0, 3'b000, K_Y, 0, 2);
    add(0, 0, 3'b000, K_A, 0);
    add(0, 0, 3'b000, K_G, 1, 4);
    add(0, 0, 3'b000, K_Y, 1, 2);
    add(0, 0, 3'b000, K_A, 1);
    add(0, 0, 3'b000, K_G, 2, 7);
    add(0, 0, 3'b001, K_G, 2);
    add(0, 0, 3'b000, K_Y, 2, 2);
    add(0, 0, 3'b000, K_A, 2);
    add(0, 0, 3'b000, K_G, 0, 2);
    // Night mode entry, blinking, and exit.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 1, 3'b000, K_G, 0, 3);
    add(0, 1, 3'b000, K_Y, 0, 2);
    add(0, 1, 3'b000, K_A, 0);
    add(0, 1, 3'b000, K_N1, 0, 2);
    add(0, 1, 3'b000, K_N0, 0, 2);
    add(0, 1, 3'b000, K_N1, 0, 2);
    add(0, 1, 3'b000, K_N0, 0);
    add(0, 0, 3'b000, K_A, 0);
    add(0, 0, 3'b000, K_G, 0, 2);
    // Reset mid-yellow overrides night/car and drops the pending request.
    add(1, 0, 3'b000, K_G, 0);
    add(0, 0, 3'b010, K_G, 0);
    add(0, 0, 3'b000, K_G, 0, 2);
    add(0, 0, 3'b000, K_Y, 0);
    add(1, 1, 3'b111, K_G, 0);
    add(0, 0, 3'b000, K_G, 0, 8);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].night, vecs[i].car);
      check("vec", i, vecs[i].grn, vecs[i].ylw, vecs[i].red, vecs[i].phase);
    end

    // Long idle lets the timer saturate; green must stay put.
    step(1, 0, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 3'b000);
      if (i % 50 == 49) check("idle_hold", i, 3'b001, 3'b000, 3'b110, 2'd0);
    end
    // A request after saturation: yellow follows on the second edge.
    step(0, 0, 3'b010);
    check("sat_req_edge1", 1, 3'b001, 3'b000, 3'b110, 2'd0);
    step(0, 0, 3'b000);
    check("sat_req_edge2", 2, 3'b000, 3'b001, 3'b110, 2'd0);

    // Bounded wait for approach 1 green; expected three edges later.
    cyc = 0;
    while (bus.grn !== 3'b010 && cyc < 20) begin
      step(0, 0, 3'b000);
      cyc++;
    end
    checks++;
    if (cyc != 3) begin
      errors++;
      $display("FAIL sat_to_green1: took %0d edges, want 3", cyc);
    end
    check("sat_green1", 0, 3'b010, 3'b000, 3'b101, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_semaforo_multi
`default_nettype wire

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 The block SHALL have parameter N_PHASES, default 2, number of approaches (2..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, phase-timer width.
REQ-003 The block SHALL have parameters T_GREEN_MIN=10, T_GREEN_MAX=30, T_YELLOW=3, T_ALLRED=2, durations in clk cycles, each 1..2^CNT_W-1, with T_GREEN_MIN <= T_GREEN_MAX.
REQ-004 Port clk, input, 1, single clock; all logic SHALL be rising-edge.
REQ-005 Port rst, input, 1, reset; synchronous and active-high.
REQ-006 Port car, input, N_PHASES, per-approach vehicle detector, level-sampled.
REQ-007 Port night, input, 1, flashing-yellow mode request.
REQ-008 Port grn, output, N_PHASES, green lamp per approach.
REQ-009 Port ylw, output, N_PHASES, yellow lamp per approach.
REQ-010 Port red, output, N_PHASES, red lamp per approach.
REQ-011 Port phase, output, clog2(N_PHASES) (min 1), index of the current or last-served approach.

Function
REQ-012 FSM states SHALL be GREEN, YELLOW, ALLRED and NIGHT; timer SHALL clear to 0 on every state entry, increment each cycle and saturate at all-ones.
REQ-013 pending[i] SHALL set when car[i]=1 and approach i is not in GREEN; it SHALL clear on the edge that enters GREEN for i, with clear winning over a simultaneous set.
REQ-014 GREEN->YELLOW SHALL occur when timer >= T_GREEN_MIN-1 and (night=1, or some pending[j], j!=phase, with car[phase]=0 or timer >= T_GREEN_MAX-1).
REQ-015 With no other request and night=0, GREEN SHALL hold indefinitely.
REQ-016 YELLOW SHALL last exactly T_YELLOW cycles, then ALLRED.
REQ-017 ALLRED SHALL last exactly T_ALLRED cycles, then go to NIGHT if night=1, otherwise to GREEN.
REQ-018 The next GREEN phase SHALL be the first pending approach searching round-robin from phase+1; with none pending it SHALL be the same phase.
REQ-019 Lamps SHALL be registered outputs, exactly one lit per approach outside NIGHT.
REQ-020 Only approach phase SHALL be green in GREEN; only approach phase SHALL be yellow in YELLOW; all other approaches SHALL be red, and all SHALL be red in ALLRED.
REQ-021 In NIGHT, grn=0 and red=0, and all ylw SHALL toggle together every T_YELLOW cycles, starting lit on entry.
REQ-022 NIGHT SHALL be exited to ALLRED when night=0, then to GREEN per REQ-018.
REQ-023 Lamp outputs SHALL change on the same edge as the state change (zero added latency).

Reset
REQ-024 On rst=1 at an edge, at any state, the FSM SHALL go to GREEN with phase=0, timer=0 and pending=0.
REQ-025 During and after reset, grn = 1 in bit 0 only, ylw=0, and red = all ones except bit 0; rst SHALL override night and car.

Structure
REQ-026 State encodings and default duration constants SHALL live in shared package semaforo_pkg.
REQ-027 Round-robin next-phase selection SHALL be a sub-module rr_arbiter (inputs req and last, output grant index and valid).

Verification (N_PHASES=3, T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1)
REQ-028 Case: rst pulse, with car=0 and night=0 for 20 cycles -> grn=3'b001, red=3'b110 throughout, phase=0.
REQ-029 Case: car=3'b100 for one cycle at cycle 0 -> grn[0] holds 4 cycles, ylw[0] 2 cycles, all-red 1 cycle, then grn=3'b100 and phase=2.
REQ-030 Case: car[0]=1 held and car[1] pulsed -> green 0 extends to exactly 8 cycles, then yellow; phase 1 is served next.
REQ-031 Case: pending=3'b110 while phase 0 is green -> phase 1 is served, then phase 2, then back to phase 0 only if it is requested.
REQ-032 Case: night=1 during GREEN -> yellow 2 cycles, all-red 1 cycle, then ylw=3'b111 toggling every 2 cycles; night=0 -> all-red 1 cycle, then GREEN.
REQ-033 Case: rst asserted mid-YELLOW -> next edge gives grn=3'b001, and pending lost.
